// File: rtl/ppm_word_transmitter_pkg.sv
// ppm_pkg: shared state type and sizing helpers for the PPM word transmitter.
// No ports; imported by the interface users, the frame timer and the top level.
package ppm_pkg;

    typedef enum logic [1:0] {PPM_IDLE, PPM_SLOT, PPM_GUARD} ppm_state_t;

    // Number of slots in one frame (2^N).
    function automatic int ppm_slots(input int n);
        return 1 << n;
    endfunction

    // Number of N-bit symbols in a WIDTH-bit word.
    function automatic int ppm_symbols(input int width, input int n);
        return width / n;
    endfunction

    // Counter width for a counter holding 0..count-1, never narrower than 1 bit.
    function automatic int ppm_cw(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/ppm_word_transmitter_if.sv
// ppm_word_transmitter_if: valid/ready word handshake between the framing logic and the transmitter.
//   data  [WIDTH] word offered by the source
//   valid         source has a word
//   ready         transmitter can accept a word
// Modports: master = word source, slave = transmitter.
interface ppm_word_transmitter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ppm_word_transmitter_frame_timer.sv
// ppm_frame_timer: clock-within-slot and slot-within-frame counters for one PPM frame.
//   clk, rst_n     clock, asynchronous active-low reset
//   i_clear        force both counters to 0 (has priority over i_run)
//   i_run          advance the clock counter; slot index advances when it wraps
//   o_slot_index   current slot 0..2^N-1
//   o_slot_clock   current clock within the slot 0..L-1
//   o_slot_first   first clock of the current slot
//   o_frame_last   last clock of the last slot of the frame
module ppm_frame_timer
    import ppm_pkg::*;
#(
    parameter int N = 2,
    parameter int L = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic                   i_run,
    output logic [N-1:0]           o_slot_index,
    output logic [ppm_cw(L)-1:0]   o_slot_clock,
    output logic                   o_slot_first,
    output logic                   o_frame_last
);
    localparam int            CW        = ppm_cw(L);
    localparam logic [CW-1:0] CLK_LAST  = CW'(L - 1);
    localparam logic [N-1:0]  SLOT_LAST = N'(ppm_slots(N) - 1);

    logic [CW-1:0] r_clock;
    logic [N-1:0]  r_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clock <= '0;
            r_slot  <= '0;
        end else if (i_clear) begin
            r_clock <= '0;
            r_slot  <= '0;
        end else if (i_run) begin
            r_clock <= (r_clock == CLK_LAST) ? '0 : r_clock + 1'b1;
            if (r_clock == CLK_LAST)
                r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
        end
    end

    assign o_slot_index = r_slot;
    assign o_slot_clock = r_clock;
    assign o_slot_first = r_clock == '0;
    assign o_frame_last = (r_clock == CLK_LAST) && (r_slot == SLOT_LAST);
endmodule

// File: rtl/ppm_word_transmitter.sv
// ppm_word_transmitter: serialises a word MSB-first into N-bit symbols, each sent as a PPM frame.
//   clk, rst_n    clock, asynchronous active-low reset
//   bus           slave side of the word handshake (data, valid in; ready out)
//   pulse         modulated output, high at the start of the slot matching the symbol
//   busy          a word is being transmitted
//   symbol_done   strobe on the last clock of each symbol (frame plus guard)
//   word_done     strobe on the last clock of the word's final symbol
module ppm_word_transmitter
    import ppm_pkg::*;
#(
    parameter int N         = 2,
    parameter int L         = 4,
    parameter int WIDTH     = 8,
    parameter int PULSE_LEN = 4,
    parameter int GUARD     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ppm_word_transmitter_if.slave bus,
    output logic                  pulse,
    output logic                  busy,
    output logic                  symbol_done,
    output logic                  word_done
);
    localparam int            S      = ppm_symbols(WIDTH, N);
    localparam int            CW     = ppm_cw(L);
    localparam int            SW     = ppm_cw(S);
    localparam int            GW     = ppm_cw(GUARD + 1);
    localparam logic [SW-1:0] S_LAST = SW'(S - 1);
    localparam logic [GW-1:0] G_LAST = GW'((GUARD > 0) ? GUARD - 1 : 0);

    if (WIDTH % N != 0) begin : g_bad_width
        $error("ppm_word_transmitter: WIDTH must be a multiple of N");
    end
    if (PULSE_LEN < 1 || PULSE_LEN > L) begin : g_bad_pulse
        $error("ppm_word_transmitter: PULSE_LEN must be within 1..L");
    end

    ppm_state_t       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [SW-1:0]    r_sym;
    logic [GW-1:0]    r_guard;
    logic [N-1:0]     w_slot_index;
    logic [CW-1:0]    w_slot_clock;
    logic             w_slot_first;
    logic             w_frame_last;
    logic             w_in_pulse;
    logic             w_end;
    logic             w_last_sym;

    // Timer is held at zero while idle, so every word starts at slot 0, clock 0.
    ppm_frame_timer #(.N(N), .L(L)) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (r_state == PPM_IDLE),
        .i_run        (r_state == PPM_SLOT),
        .o_slot_index (w_slot_index),
        .o_slot_clock (w_slot_clock),
        .o_slot_first (w_slot_first),
        .o_frame_last (w_frame_last)
    );

    assign w_in_pulse  = (PULSE_LEN == 1) ? w_slot_first : (32'(w_slot_clock) < PULSE_LEN);
    // Without a guard interval the symbol ends on the frame's last clock.
    assign w_end       = (GUARD == 0) ? (r_state == PPM_SLOT && w_frame_last)
                                      : (r_state == PPM_GUARD && r_guard == G_LAST);
    assign w_last_sym  = r_sym == S_LAST;
    assign pulse       = (r_state == PPM_SLOT) && (w_slot_index == r_shift[WIDTH-1 -: N]) && w_in_pulse;
    assign symbol_done = w_end;
    assign word_done   = w_end && w_last_sym;
    assign busy        = r_state != PPM_IDLE;
    assign bus.ready   = r_state == PPM_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PPM_IDLE;
            r_shift <= '0;
            r_sym   <= '0;
            r_guard <= '0;
        end else begin
            case (r_state)
                PPM_IDLE: if (bus.valid) begin
                    r_shift <= bus.data;
                    r_sym   <= '0;
                    r_guard <= '0;
                    r_state <= PPM_SLOT;
                end
                PPM_SLOT:  if (w_frame_last && GUARD > 0) r_state <= PPM_GUARD;
                PPM_GUARD: r_guard <= r_guard + 1'b1;
                default:   r_state <= PPM_IDLE;
            endcase
            // Symbol end overrides the per-state updates above.
            if (w_end) begin
                r_guard <= '0;
                if (w_last_sym) begin
                    r_state <= PPM_IDLE;
                end else begin
                    r_state <= PPM_SLOT;
                    r_shift <= r_shift << N;
                    r_sym   <= r_sym + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ppm_word_transmitter.sv
// tb_ppm_word_transmitter: directed checks of three transmitter configurations.
module tb_ppm_word_transmitter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ppm_word_transmitter_if #(.WIDTH(8)) bus_a ();
    ppm_word_transmitter_if #(.WIDTH(8)) bus_b ();
    ppm_word_transmitter_if #(.WIDTH(4)) bus_c ();

    logic pulse_a, busy_a, sd_a, wd_a;
    logic pulse_b, busy_b, sd_b, wd_b;
    logic pulse_c, busy_c, sd_c, wd_c;

    // A: guard interval, short pulse
    ppm_word_transmitter #(.N(2), .L(4), .WIDTH(8), .PULSE_LEN(2), .GUARD(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .pulse(pulse_a), .busy(busy_a), .symbol_done(sd_a), .word_done(wd_a));
    // B: full-slot pulse, no guard
    ppm_word_transmitter #(.N(2), .L(4), .WIDTH(8), .PULSE_LEN(4), .GUARD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .pulse(pulse_b), .busy(busy_b), .symbol_done(sd_b), .word_done(wd_b));
    // C: one bit per symbol, one clock per slot
    ppm_word_transmitter #(.N(1), .L(1), .WIDTH(4), .PULSE_LEN(1), .GUARD(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c),
        .pulse(pulse_c), .busy(busy_c), .symbol_done(sd_c), .word_done(wd_c));

    function automatic logic in_range(input int c, input int lo, input int hi);
        return c >= lo && c <= hi;
    endfunction

    task test_reset;
        bus_a.valid = 0; bus_a.data = '0;
        bus_b.valid = 0; bus_b.data = '0;
        bus_c.valid = 0; bus_c.data = '0;
        rst_n = 0;
        #12;
        checks++;
        if ({pulse_a, sd_a, wd_a, busy_a, bus_a.ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_a: {pulse,sym_done,word_done,busy,ready}=%b want 00001",
                     {pulse_a, sd_a, wd_a, busy_a, bus_a.ready});
        end
        checks++;
        if ({pulse_b, sd_b, wd_b, busy_b, bus_b.ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_b: {pulse,sym_done,word_done,busy,ready}=%b want 00001",
                     {pulse_b, sd_b, wd_b, busy_b, bus_b.ready});
        end
        @(negedge clk) rst_n = 1;
        @(negedge clk);
        checks++;
        if ({pulse_c, sd_c, wd_c, busy_c, bus_c.ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_c_release: {pulse,sym_done,word_done,busy,ready}=%b want 00001",
                     {pulse_c, sd_c, wd_c, busy_c, bus_c.ready});
        end
    endtask

    // N=2 L=4 PULSE_LEN=2 GUARD=3 (F=19), word 10_01_11_00
    task test_guard_frame;
        logic [4:0] exp;
        @(negedge clk); bus_a.data = 8'b10_01_11_00; bus_a.valid = 1;
        @(posedge clk); #1 bus_a.valid = 0; bus_a.data = 8'h00;
        for (int c = 1; c <= 77; c++) begin
            exp = {in_range(c, 9, 10) || in_range(c, 24, 25) || in_range(c, 51, 52) || in_range(c, 58, 59),
                   c == 19 || c == 38 || c == 57 || c == 76, c == 76, c <= 76, c == 77};
            checks++;
            if ({pulse_a, sd_a, wd_a, busy_a, bus_a.ready} !== exp) begin
                errors++;
                $display("FAIL guard_frame cycle %0d: {pulse,sym_done,word_done,busy,ready}=%b want %b",
                         c, {pulse_a, sd_a, wd_a, busy_a, bus_a.ready}, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    // N=2 L=4 PULSE_LEN=4 GUARD=0 (F=16), word 11_00_00_11: pulse spans the 0->1 frame boundary
    task test_frame_boundary;
        logic [4:0] exp;
        @(negedge clk); bus_b.data = 8'b11_00_00_11; bus_b.valid = 1;
        @(posedge clk); #1 bus_b.valid = 0;
        for (int c = 1; c <= 65; c++) begin
            exp = {in_range(c, 13, 20) || in_range(c, 33, 36) || in_range(c, 61, 64),
                   c % 16 == 0 && c <= 64, c == 64, c <= 64, c == 65};
            checks++;
            if ({pulse_b, sd_b, wd_b, busy_b, bus_b.ready} !== exp) begin
                errors++;
                $display("FAIL frame_boundary cycle %0d: {pulse,sym_done,word_done,busy,ready}=%b want %b",
                         c, {pulse_b, sd_b, wd_b, busy_b, bus_b.ready}, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    // valid held high: word 01_10_11_00 then 00_11_01_10 accepted at cycle 65
    task test_back_to_back;
        logic [4:0] exp;
        @(negedge clk); bus_b.data = 8'b01_10_11_00; bus_b.valid = 1;
        @(posedge clk); #1;
        for (int c = 1; c <= 131; c++) begin
            exp = {in_range(c, 5, 8) || in_range(c, 25, 28) || in_range(c, 45, 52) ||
                   in_range(c, 66, 69) || in_range(c, 94, 97) || in_range(c, 102, 105) || in_range(c, 122, 125),
                   (c <= 64 && c % 16 == 0) || (c > 65 && c <= 129 && (c - 65) % 16 == 0),
                   c == 64 || c == 129, c != 65 && c <= 129, c == 65 || c >= 130};
            checks++;
            if ({pulse_b, sd_b, wd_b, busy_b, bus_b.ready} !== exp) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: {pulse,sym_done,word_done,busy,ready}=%b want %b",
                         c, {pulse_b, sd_b, wd_b, busy_b, bus_b.ready}, exp);
            end
            bus_b.data  = (c < 65) ? ((c % 2 == 1) ? 8'hFF : 8'h00) : 8'b00_11_01_10;
            bus_b.valid = c < 129;
            @(posedge clk); #1;
        end
    endtask

    // reset in cycle 10 while the symbol-0 pulse is high, then a fresh word
    task test_reset_mid_word;
        logic [4:0] exp;
        @(negedge clk); bus_b.data = 8'b10_01_11_00; bus_b.valid = 1;
        @(posedge clk); #1 bus_b.valid = 0;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (pulse_b !== in_range(c, 9, 10)) begin
                errors++;
                $display("FAIL reset_mid_pre cycle %0d: pulse=%b want %b", c, pulse_b, in_range(c, 9, 10));
            end
            if (c < 10) begin
                @(posedge clk); #1;
            end
        end
        rst_n = 0;
        #1;
        checks++;
        if ({pulse_b, sd_b, wd_b, busy_b, bus_b.ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_mid_abort: {pulse,sym_done,word_done,busy,ready}=%b want 00001",
                     {pulse_b, sd_b, wd_b, busy_b, bus_b.ready});
        end
        @(negedge clk) rst_n = 1;
        @(negedge clk); bus_b.data = 8'b11_00_00_00; bus_b.valid = 1;
        @(posedge clk); #1 bus_b.valid = 0;
        for (int c = 1; c <= 65; c++) begin
            exp = {in_range(c, 13, 20) || in_range(c, 33, 36) || in_range(c, 49, 52),
                   c % 16 == 0 && c <= 64, c == 64, c <= 64, c == 65};
            checks++;
            if ({pulse_b, sd_b, wd_b, busy_b, bus_b.ready} !== exp) begin
                errors++;
                $display("FAIL reset_mid_next cycle %0d: {pulse,sym_done,word_done,busy,ready}=%b want %b",
                         c, {pulse_b, sd_b, wd_b, busy_b, bus_b.ready}, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    // N=1 L=1 WIDTH=4: word 1010 gives pulse 0,1,1,0,0,1,1,0
    task test_one_bit_symbols;
        logic [4:0] exp;
        @(negedge clk); bus_c.data = 4'b1010; bus_c.valid = 1;
        @(posedge clk); #1 bus_c.valid = 0;
        for (int c = 1; c <= 9; c++) begin
            exp = {c == 2 || c == 3 || c == 6 || c == 7, c % 2 == 0 && c <= 8, c == 8, c <= 8, c == 9};
            checks++;
            if ({pulse_c, sd_c, wd_c, busy_c, bus_c.ready} !== exp) begin
                errors++;
                $display("FAIL one_bit cycle %0d: {pulse,sym_done,word_done,busy,ready}=%b want %b",
                         c, {pulse_c, sd_c, wd_c, busy_c, bus_c.ready}, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    // valid pulses during transmission of 8'h00 must be ignored
    task test_valid_while_busy;
        logic [4:0] exp;
        @(negedge clk); bus_b.data = 8'h00; bus_b.valid = 1;
        @(posedge clk); #1 bus_b.valid = 0;
        for (int c = 1; c <= 72; c++) begin
            exp = {in_range(c, 1, 4) || in_range(c, 17, 20) || in_range(c, 33, 36) || in_range(c, 49, 52),
                   c % 16 == 0 && c <= 64, c == 64, c <= 64, c >= 65};
            checks++;
            if ({pulse_b, sd_b, wd_b, busy_b, bus_b.ready} !== exp) begin
                errors++;
                $display("FAIL valid_busy cycle %0d: {pulse,sym_done,word_done,busy,ready}=%b want %b",
                         c, {pulse_b, sd_b, wd_b, busy_b, bus_b.ready}, exp);
            end
            bus_b.valid = c == 20 || c == 40 || c == 63;
            bus_b.data  = 8'hFF;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_guard_frame();
        test_frame_boundary();
        test_back_to_back();
        test_reset_mid_word();
        test_one_bit_symbols();
        test_valid_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
